// File: rtl/kilit_cozucu.sv
// Lock-code solver: scans the 32 (sag, sol) step pairs in order and reports
// the first pair whose code 5*((s - 2l) mod 8) equals the captured target.
module kilit_cozucu (
    input  logic       clk,
    input  logic       rst,
    input  logic       baslat,
    input  logic [5:0] kilit_sifre,
    output logic [2:0] sag_adim,
    output logic [1:0] sol_adim,
    output logic       mesgul,
    output logic       bitti,
    output logic       bulundu
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned KOD_W  = 6;
    localparam int unsigned SAG_W  = 3;
    localparam int unsigned SOL_W  = 2;
    localparam logic [IDX_W-1:0] SON_IDX = 5'd31;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ARA   = 2'd1,
        BITTI = 2'd2
    } durum_e;

    durum_e             state_q, state_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [KOD_W-1:0]   sifre_q, sifre_d;
    logic [SAG_W-1:0]   sag_q, sag_d;
    logic [SOL_W-1:0]   sol_q, sol_d;
    logic               bulundu_q, bulundu_d;
    logic               bitti_q, bitti_d;
    logic               mesgul_q, mesgul_d;

    logic [SAG_W-1:0]   fark_c;
    logic [4:0]         x1_c;
    logic [4:0]         x4_c;
    logic [KOD_W-1:0]   kod_c;

    // kod = x + 4x built as one 5-bit add; its carry lands in bit 5
    always_comb begin
        fark_c = SAG_W'(i_q[4:2] - {i_q[1:0], 1'b0});
        x1_c   = {2'b00, fark_c};
        x4_c   = {fark_c, 2'b00};
        kod_c  = KOD_W'(x1_c) + KOD_W'(x4_c);
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        sifre_d   = sifre_q;
        sag_d     = sag_q;
        sol_d     = sol_q;
        bulundu_d = bulundu_q;

        case (state_q)
            BOSTA: begin
                if (baslat) begin
                    sifre_d   = kilit_sifre;
                    i_d       = '0;
                    bulundu_d = 1'b0;
                    state_d   = ARA;
                end
            end
            ARA: begin
                if (kod_c == sifre_q) begin
                    sag_d     = i_q[4:2];
                    sol_d     = i_q[1:0];
                    bulundu_d = 1'b1;
                    state_d   = BITTI;
                end else if (i_q == SON_IDX) begin
                    bulundu_d = 1'b0;
                    state_d   = BITTI;
                end else begin
                    i_d = IDX_W'(i_q + 5'd1);
                end
            end
            BITTI:   state_d = BOSTA;
            default: state_d = BOSTA;
        endcase

        // status flags follow the next state so they line up with state_q
        bitti_d  = (state_d == BITTI);
        mesgul_d = (state_d == ARA) || (state_d == BITTI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOSTA;
            i_q       <= '0;
            sifre_q   <= '0;
            sag_q     <= '0;
            sol_q     <= '0;
            bulundu_q <= 1'b0;
            bitti_q   <= 1'b0;
            mesgul_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            sifre_q   <= sifre_d;
            sag_q     <= sag_d;
            sol_q     <= sol_d;
            bulundu_q <= bulundu_d;
            bitti_q   <= bitti_d;
            mesgul_q  <= mesgul_d;
        end
    end

    assign sag_adim = sag_q;
    assign sol_adim = sol_q;
    assign bulundu  = bulundu_q;
    assign bitti    = bitti_q;
    assign mesgul   = mesgul_q;

endmodule

// File: tb/tb_kilit_cozucu.sv
// Bench for kilit_cozucu: hand-computed vector table, corner sequences,
// exhaustive and random sweeps against a brute-force search model.
module tb_kilit_cozucu;

    logic       clk;
    logic       rst;
    logic       baslat;
    logic [5:0] kilit_sifre;
    logic [2:0] sag_adim;
    logic [1:0] sol_adim;
    logic       mesgul;
    logic       bitti;
    logic       bulundu;

    int vectors;
    int miscompares;
    int exp_sag;
    int exp_sol;

    kilit_cozucu dut (
        .clk         (clk),
        .rst         (rst),
        .baslat      (baslat),
        .kilit_sifre (kilit_sifre),
        .sag_adim    (sag_adim),
        .sol_adim    (sol_adim),
        .mesgul      (mesgul),
        .bitti       (bitti),
        .bulundu     (bulundu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int code;
        int found;
        int sag;
        int sol;
        int lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Code of a step pair straight from its definition
    function automatic int kod(input int s, input int l);
        return 5 * ((((s - 2 * l) % 8) + 8) % 8);
    endfunction

    // Brute-force first-match search; latency is edges from accept to bitti
    task automatic ref_search(input int code, output int f, output int s,
                              output int l, output int lat);
        f = 0; s = 0; l = 0; lat = 32;
        for (int idx = 0; idx < 32; idx++) begin
            if (f == 0 && kod(idx / 4, idx % 4) == code) begin
                f = 1; s = idx / 4; l = idx % 4; lat = idx + 1;
            end
        end
    endtask

    task automatic run_search(input int code, input int e_found, input int e_sag,
                              input int e_sol, input int e_lat, input string tag);
        int n;
        bit got;
        @(negedge clk);
        baslat = 1'b1;
        kilit_sifre = 6'(code);
        @(posedge clk); #1;
        chk({tag, "/mesgul_start"}, int'(mesgul), 1);
        chk({tag, "/bulundu_clear"}, int'(bulundu), 0);
        @(negedge clk);
        baslat = 1'b0;
        kilit_sifre = 6'($urandom);
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bitti) got = 1'b1;
        end
        chk({tag, "/latency"}, n, e_lat);
        chk({tag, "/bulundu"}, int'(bulundu), e_found);
        chk({tag, "/sag"}, int'(sag_adim), e_sag);
        chk({tag, "/sol"}, int'(sol_adim), e_sol);
        if (bulundu) chk({tag, "/kod"}, kod(int'(sag_adim), int'(sol_adim)), code);
        @(posedge clk); #1;
        chk({tag, "/bitti_width"}, int'(bitti), 0);
        chk({tag, "/mesgul_idle"}, int'(mesgul), 0);
    endtask

    task automatic model_search(input int code, input string tag);
        int f, s, l, lat;
        ref_search(code, f, s, l, lat);
        if (f != 0) begin
            exp_sag = s;
            exp_sol = l;
        end
        run_search(code, f, exp_sag, exp_sol, lat, tag);
    endtask

    initial begin
        int pulses;
        int n;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        baslat      = 1'b1;
        kilit_sifre = 6'd0;

        tbl[0] = '{code: 0,  found: 1, sag: 0, sol: 0, lat: 1};
        tbl[1] = '{code: 5,  found: 1, sag: 1, sol: 0, lat: 5};
        tbl[2] = '{code: 35, found: 1, sag: 1, sol: 1, lat: 6};
        tbl[3] = '{code: 3,  found: 0, sag: 1, sol: 1, lat: 32};
        tbl[4] = '{code: 40, found: 0, sag: 1, sol: 1, lat: 32};
        tbl[5] = '{code: 10, found: 1, sag: 0, sol: 3, lat: 4};
        tbl[6] = '{code: 30, found: 1, sag: 0, sol: 1, lat: 2};
        tbl[7] = '{code: 20, found: 1, sag: 0, sol: 2, lat: 3};
        tbl[8] = '{code: 63, found: 0, sag: 0, sol: 2, lat: 32};

        // reset wins over a held start request
        repeat (3) @(posedge clk);
        #1;
        chk("rst/sag", int'(sag_adim), 0);
        chk("rst/sol", int'(sol_adim), 0);
        chk("rst/bulundu", int'(bulundu), 0);
        chk("rst/bitti", int'(bitti), 0);
        chk("rst/mesgul", int'(mesgul), 0);
        @(negedge clk);
        rst = 1'b0;
        baslat = 1'b0;
        @(posedge clk);

        foreach (tbl[t])
            run_search(tbl[t].code, tbl[t].found, tbl[t].sag, tbl[t].sol,
                       tbl[t].lat, $sformatf("tbl%0d", t));

        // second start at E2 with a different code is ignored
        @(negedge clk);
        baslat = 1'b1; kilit_sifre = 6'd35;
        @(posedge clk);
        @(negedge clk);
        baslat = 1'b0; kilit_sifre = 6'd0;
        @(posedge clk);
        @(negedge clk);
        baslat = 1'b1;
        @(posedge clk);
        @(negedge clk);
        baslat = 1'b0;
        n = 2;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bitti) break;
        end
        chk("ignore/latency", n, 6);
        chk("ignore/bulundu", int'(bulundu), 1);
        chk("ignore/sag", int'(sag_adim), 1);
        chk("ignore/sol", int'(sol_adim), 1);
        @(posedge clk); #1;

        // reset at E3 aborts the search without a completion pulse
        @(negedge clk);
        baslat = 1'b1; kilit_sifre = 6'd35;
        @(posedge clk);
        @(negedge clk);
        baslat = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort/sag", int'(sag_adim), 0);
        chk("abort/sol", int'(sol_adim), 0);
        chk("abort/bulundu", int'(bulundu), 0);
        chk("abort/bitti", int'(bitti), 0);
        chk("abort/mesgul", int'(mesgul), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bitti) pulses++;
        end
        chk("abort/no_pulse", pulses, 0);
        run_search(35, 1, 1, 1, 6, "cold35");

        // held start: accept, BITTI, BOSTA, accept ... one pulse every 3 edges
        @(negedge clk);
        baslat = 1'b1; kilit_sifre = 6'd0;
        pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (bitti) begin
                pulses++;
                chk("b2b/bulundu", int'(bulundu), 1);
            end
        end
        chk("b2b/pulses", pulses, 4);
        @(negedge clk);
        baslat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_sag = 0;
        exp_sol = 0;

        for (int c = 0; c < 64; c++) model_search(c, $sformatf("sweep%0d", c));
        for (int r = 0; r < 30; r++) model_search(int'($urandom_range(0, 63)), $sformatf("rnd%0d", r));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kilit_cozucu.md
KILIT_COZUCU -- requirements
Module: kilit_cozucu

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 baslat  input  1  start request; sampled only in state BOSTA.
REQ-005 kilit_sifre  input  6  target lock code; captured on the accepting edge only.
REQ-006 sag_adim  output  3  right-step count of the last found solution.
REQ-007 sol_adim  output  2  left-step count of the last found solution.
REQ-008 mesgul  output  1  high while state is ARA or BITTI.
REQ-009 bitti  output  1  one-cycle completion pulse.
REQ-010 bulundu  output  1  result flag: 1 if the last search matched; valid from the bitti cycle until the next accepted start.

Function
REQ-011 Code function SHALL be kod(s,l) = 5 * ((s - 2*l) mod 8), with s = sag value (0..7) and l = sol value (0..3).
REQ-012 kod SHALL have a range of 0..35 and SHALL be compared as 6-bit unsigned against the captured kilit_sifre.
REQ-013 kod SHALL be formed with gate-level or adder-level structure using a 5-bit sum of x and x<<2, where x = 3-bit difference; the carry SHALL become bit 5.
REQ-014 Candidate index i (5-bit, 0..31) SHALL map to s = i[4:2] and l = i[1:0], so sag is the outer loop and sol the inner loop.
REQ-015 FSM states SHALL be BOSTA, ARA and BITTI, encoded in 2 bits; the fourth encoding SHALL go to BOSTA.
REQ-016 BOSTA with baslat=1 SHALL capture kilit_sifre, set i=0, clear bulundu, and go to ARA; baslat=0 SHALL stay in BOSTA.
REQ-017 ARA SHALL evaluate exactly one candidate per cycle, the one at the current i.
REQ-018 In ARA, a match SHALL load sag_adim/sol_adim from i, set bulundu=1, and go to BITTI.
REQ-019 In ARA, no match with i=31 SHALL set bulundu=0, leave sag_adim/sol_adim unchanged, and go to BITTI.
REQ-020 In ARA, no match with i<31 SHALL increment i.
REQ-021 BITTI SHALL assert bitti for exactly one cycle, then go to BOSTA unconditionally.
REQ-022 The first match (lowest i) SHALL win.
REQ-023 Latency: if the edge that accepts baslat is E0 and the first match is at index k, the FSM SHALL enter BITTI at edge E(k+1).
REQ-024 With no match, the FSM SHALL enter BITTI at E32.
REQ-025 baslat SHALL be ignored in ARA and BITTI, with no queuing.
REQ-026 kilit_sifre changes after E0 SHALL have no effect.
REQ-027 Back-to-back operation: baslat held high SHALL restart the search on the edge after BITTI, with bulundu and sag/sol holding until then.
REQ-028 bitti and mesgul SHALL be registered or decoded from state only, never combinational from inputs.

Reset
REQ-029 rst=1 on an edge SHALL force state BOSTA, i=0, captured code=0, sag_adim=0, sol_adim=0, bulundu=0, bitti=0 and mesgul=0.
REQ-030 rst SHALL override baslat.
REQ-031 rst mid-search SHALL abort the search with no bitti pulse.
REQ-032 The first start after reset SHALL behave identically to a cold start.

Verification
REQ-033 kilit_sifre=0, baslat pulse -> bitti at E1, bulundu=1, sag_adim=0, sol_adim=0.
REQ-034 kilit_sifre=5 -> match at i=4, bitti at E5, sag_adim=1, sol_adim=0.
REQ-035 kilit_sifre=35 -> match at i=5, bitti at E6, sag_adim=1, sol_adim=1.
REQ-036 kilit_sifre=3 (not a multiple of 5) -> bitti at E32, bulundu=0, sag/sol unchanged from the previous result; then kilit_sifre=40 -> bulundu=0.
REQ-037 Start with kilit_sifre=35, assert rst at E3 -> no bitti pulse, all outputs 0 next cycle.
REQ-038 Start with kilit_sifre=35, pulse baslat again at E2 with kilit_sifre=0 -> ignored, result sag=1, sol=1.
REQ-039 Exhaustive sweep of kilit_sifre 0..63 -> for each, bulundu=1 iff a multiple of 5 ≤ 35, and kod(sag_adim, sol_adim) equals kilit_sifre when found.
